// File: rtl/output_layer_pkg.sv
// Shared constants and state encoding for the digit-classifier output layer.
// The argmax stage imports ACC_W from here so score widths stay in lockstep.
package output_layer_pkg;

  localparam int N_OUT = 10;
  localparam int ACC_W = 26;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_BIAS = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_mac_lane.sv
// One class lane: signed multiply-accumulate with saturation, bias add and clear.
// A clear coinciding with a MAC restarts the lane from that beat's product.
module sat_mac_lane
  import output_layer_pkg::*;
#(
  parameter int ACT_W = 8,
  parameter int W_W   = 8,
  parameter int B_W   = 16
) (
  input  logic                    clk,
  input  logic                    i_clr,
  input  logic                    i_mac,
  input  logic                    i_bias,
  input  logic signed [ACT_W-1:0] i_act,
  input  logic signed [W_W-1:0]   i_w,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int P_W = ACT_W + W_W;

  // Clamp on signed overflow: the extra sum bit disagrees with the sign bit.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) return sum[ACC_W] ? ACC_MIN : ACC_MAX;
    return sum[ACC_W-1:0];
  endfunction

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = P_W'(i_act) * P_W'(i_w);
  assign w_prod_ext = {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-B_W){i_b[B_W-1]}}, i_b};

  always_ff @(posedge clk) begin
    if (i_clr)       r_acc <= i_mac ? w_prod_ext : '0;
    else if (i_mac)  r_acc <= sat_add(r_acc, w_prod_ext);
    else if (i_bias) r_acc <= sat_add(r_acc, w_bias_ext);
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/output_layer_scorer.sv
// Output-layer scorer: accumulates N_HIDDEN weighted activations into 10 class
// scores, adds biases and presents them with a one-cycle scores_valid pulse.
module output_layer_scorer
  import output_layer_pkg::*;
#(
  parameter int N_HIDDEN = 32,
  parameter int ACT_W    = 8,
  parameter int W_W      = 8,
  parameter int B_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic signed [ACT_W-1:0] h_act,
  input  logic [N_OUT*W_W-1:0]    w_bus,
  input  logic [N_OUT*B_W-1:0]    b_bus,
  output logic signed [ACC_W-1:0] s0,
  output logic signed [ACC_W-1:0] s1,
  output logic signed [ACC_W-1:0] s2,
  output logic signed [ACC_W-1:0] s3,
  output logic signed [ACC_W-1:0] s4,
  output logic signed [ACC_W-1:0] s5,
  output logic signed [ACC_W-1:0] s6,
  output logic signed [ACC_W-1:0] s7,
  output logic signed [ACC_W-1:0] s8,
  output logic signed [ACC_W-1:0] s9,
  output logic                    scores_valid,
  output logic                    frame_err
);

  localparam int               CNT_W    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_HIDDEN - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic                    r_vld_p0;
  logic                    r_err_p0;
  logic signed [ACC_W-1:0] r_s   [N_OUT];
  logic signed [ACC_W-1:0] w_acc [N_OUT];
  logic                    w_accept;
  logic                    w_last_beat;
  logic                    w_bias;
  logic                    w_clr;

  assign in_ready    = (r_state == ST_ACC) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (r_cnt == CNT_LAST);
  assign w_bias      = (r_state == ST_BIAS);
  // Lanes are cleared one cycle after ST_DONE, the same edge that copies them
  // to s0..s9, so the next frame's first beat can already land on that edge.
  assign w_clr       = rst || r_vld_p0;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    sat_mac_lane #(
      .ACT_W (ACT_W),
      .W_W   (W_W),
      .B_W   (B_W)
    ) u_lane (
      .clk    (clk),
      .i_clr  (w_clr),
      .i_mac  (w_accept),
      .i_bias (w_bias),
      .i_act  (h_act),
      .i_w    (w_bus[k*W_W +: W_W]),
      .i_b    (b_bus[k*B_W +: B_W]),
      .o_acc  (w_acc[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ACC;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_vld_p0     <= 1'b0;
      r_err_p0     <= 1'b0;
      scores_valid <= 1'b0;
      frame_err    <= 1'b0;
      for (int k = 0; k < N_OUT; k++) r_s[k] <= '0;
    end else begin
      // Output stage: publish the finished frame one cycle after ST_DONE.
      scores_valid <= r_vld_p0;
      frame_err    <= r_vld_p0 && r_err_p0;
      r_vld_p0     <= 1'b0;
      if (r_vld_p0) begin
        for (int k = 0; k < N_OUT; k++) r_s[k] <= w_acc[k];
      end
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (in_last != w_last_beat) r_err <= 1'b1;
            if (w_last_beat) r_state <= ST_BIAS;
          end
        end
        ST_BIAS: r_state <= ST_DONE;
        ST_DONE: begin
          r_vld_p0 <= 1'b1;
          r_err_p0 <= r_err;
          r_err    <= 1'b0;
          r_cnt    <= '0;
          r_state  <= ST_ACC;
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign s0 = r_s[0];
  assign s1 = r_s[1];
  assign s2 = r_s[2];
  assign s3 = r_s[3];
  assign s4 = r_s[4];
  assign s5 = r_s[5];
  assign s6 = r_s[6];
  assign s7 = r_s[7];
  assign s8 = r_s[8];
  assign s9 = r_s[9];

endmodule
